// File: rtl/video_pkg.sv
// Shared video types: 9-bit RGB pixel, component width and the dimming helper.
// The replay state enum also lives here so the bench can reuse it.
package video_pkg;
  localparam int RGBW = 9;
  localparam int CW   = 3;

  typedef logic [RGBW-1:0] rgb_t;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } half_e;

  // Halve every colour component independently.
  function automatic rgb_t dim_rgb(input rgb_t p);
    rgb_t r;
    r = '0;
    for (int i = 0; i < RGBW / CW; i++)
      r[i*CW +: CW] = p[i*CW +: CW] >> 1;
    return r;
  endfunction
endpackage

// File: rtl/scandoubler_if.sv
// Video bundle between the pixel serializer and the output pins.
// master drives strobes, pixels and syncs; slave returns the doubled stream.
interface scandoubler_if;
  import video_pkg::*;

  logic cei;
  logic ceo;
  logic scanl;
  rgb_t rgbi;
  logic hsi;
  logic vsi;
  rgb_t rgbo;
  logic hso;
  logic vso;

  modport master (
    output cei, ceo, scanl, rgbi, hsi, vsi,
    input  rgbo, hso, vso
  );

  modport slave (
    input  cei, ceo, scanl, rgbi, hsi, vsi,
    output rgbo, hso, vso
  );
endinterface

// File: rtl/scandoubler_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, 2^(AW+1) x 9.
// Write port gated by the input strobe, registered read gated by the output strobe.
module linebuf
  import video_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we_i,
  input  logic [AW:0] wa_i,
  input  rgb_t        wd_i,
  input  logic        re_i,
  input  logic [AW:0] ra_i,
  output rgb_t        rd_o
);
  rgb_t mem_q [2**(AW+1)];
  rgb_t rd_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_q <= '0;
    else if (re_i) rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;
endmodule

// File: rtl/scandoubler.sv
// Line-doubling scan converter: each captured 15 kHz line is replayed twice
// at double pixel rate during the next input line, second pass optionally dimmed.
module scandoubler
  import video_pkg::*;
#(
  parameter int AW  = 10,
  parameter int HSW = 46
) (
  input  logic         clock,
  input  logic         reset,
  scandoubler_if.slave vid
);
  typedef logic [AW-1:0] cnt_t;

  localparam cnt_t CMAX = '1;
  localparam cnt_t HSWC = cnt_t'(HSW);

  logic  hsd_q;
  logic  bank_q;
  logic  pend_q;
  cnt_t  wcnt_q, wcnt_d;
  cnt_t  len_q, len_d;
  cnt_t  rcnt_q, rcnt_d;
  half_e half_q;
  logic  dim_q;
  logic  hso_q;
  logic  vso_q;

  logic  ls;
  logic  resync;
  logic  wrap;
  logic  we;
  rgb_t  rd;

  assign ls     = vid.cei & vid.hsi & ~hsd_q;
  assign resync = pend_q | ls;
  assign wrap   = (rcnt_q == len_q);
  assign we     = vid.cei & ~ls;

  // Write counter saturates so overlong lines keep hitting the last slot.
  always_comb begin
    wcnt_d = wcnt_q;
    len_d  = len_q;
    if (ls) begin
      len_d  = wcnt_q;
      wcnt_d = '0;
    end else if (wcnt_q != CMAX) begin
      wcnt_d = wcnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsd_q  <= 1'b0;
      bank_q <= 1'b0;
      wcnt_q <= '0;
      len_q  <= CMAX;
    end else if (vid.cei) begin
      hsd_q  <= vid.hsi;
      wcnt_q <= wcnt_d;
      len_q  <= len_d;
      if (ls) bank_q <= ~bank_q;
    end
  end

  // Holds a line start until the output side's next strobe consumes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pend_q <= 1'b0;
    else if (vid.ceo) pend_q <= 1'b0;
    else if (ls) pend_q <= 1'b1;
  end

  assign rcnt_d = (resync | wrap) ? '0 : rcnt_q + cnt_t'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rcnt_q <= '0;
      half_q <= FIRST;
      hso_q  <= 1'b0;
      vso_q  <= 1'b0;
      dim_q  <= 1'b0;
    end else if (vid.ceo) begin
      rcnt_q <= rcnt_d;
      hso_q  <= (rcnt_q < HSWC);
      dim_q  <= vid.scanl & (half_q == SECOND);
      if (resync | wrap) vso_q <= vid.vsi;
      unique case (1'b1)
        resync:         half_q <= FIRST;
        wrap & ~resync: half_q <= (half_q == FIRST) ? SECOND : FIRST;
        default:        ;
      endcase
    end
  end

  linebuf #(.AW(AW)) u_buf (
    .clock (clock),
    .reset (reset),
    .we_i  (we),
    .wa_i  ({bank_q, wcnt_q}),
    .wd_i  (vid.rgbi),
    .re_i  (vid.ceo),
    .ra_i  ({~bank_q, rcnt_q}),
    .rd_o  (rd)
  );

  assign vid.rgbo = dim_q ? dim_rgb(rd) : rd;
  assign vid.hso  = hso_q;
  assign vid.vso  = vso_q;
endmodule

// File: tb/tb_scandoubler.sv
// Bench for scandoubler: line-level reference model checked every clock,
// plus literal expectations on recorded per-ceo output samples.
module tb_scandoubler;
  import video_pkg::*;

  localparam int AW   = 10;
  localparam int HSW  = 46;
  localparam int NREC = 32768;

  logic clock = 1'b0;
  logic reset = 1'b1;

  scandoubler_if vif ();

  scandoubler #(.AW(AW), .HSW(HSW)) dut (
    .clock (clock),
    .reset (reset),
    .vid   (vif)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [8:0] rec_rgb [NREC];
  bit         rec_hs  [NREC];
  bit         rec_vs  [NREC];
  int         nceo = 0;
  int         ls_idx [$];

  logic [8:0] cap  [$];
  logic [8:0] disp [$];
  int         m_len, m_pos, m_pass;
  bit         m_hsd, m_pend;
  logic [8:0] m_rgb;
  bit         m_known, m_hso, m_vso;
  bit         vs_lvl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dimmed(input int p);
    int r, g, b;
    r = p / 64;
    g = (p / 8) % 8;
    b = p % 8;
    return (r / 2) * 64 + (g / 2) * 8 + b / 2;
  endfunction

  always @(posedge clock) begin
    bit ls_now;
    bit was_ceo;
    int idx;
    int px;
    ls_now  = 1'b0;
    was_ceo = reset && vif.ceo;
    idx     = nceo;
    if (!reset) begin
      cap.delete();
      disp.delete();
      m_len = 1023; m_pos = 0; m_pass = 0;
      m_hsd = 0; m_pend = 0;
      m_rgb = 0; m_known = 1; m_hso = 0; m_vso = 0;
    end else begin
      ls_now = vif.cei && vif.hsi && !m_hsd;
      if (vif.ceo) begin
        m_known = m_pos < disp.size();
        px      = m_known ? int'(disp[m_pos]) : 0;
        m_rgb   = 9'((vif.scanl && m_pass == 1) ? dimmed(px) : px);
        m_hso   = m_pos < HSW;
        if (m_pend || ls_now) begin
          m_pos = 0; m_pass = 0; m_vso = vif.vsi;
        end else if (m_pos == m_len) begin
          m_pos = 0; m_pass = 1 - m_pass; m_vso = vif.vsi;
        end else begin
          m_pos++;
        end
        m_pend = 0;
      end
      if (vif.cei) begin
        if (ls_now) begin
          m_len = (cap.size() < 1024) ? cap.size() : 1023;
          disp  = cap;
          cap.delete();
          if (!vif.ceo) m_pend = 1;
          ls_idx.push_back(idx);
        end else if (cap.size() < 1024) begin
          cap.push_back(vif.rgbi);
        end else begin
          cap[1023] = vif.rgbi;
        end
        m_hsd = vif.hsi;
      end
    end
    #1;
    if (m_known) chk("rgbo", int'(vif.rgbo), int'(m_rgb));
    chk("hso", int'(vif.hso), int'(m_hso));
    chk("vso", int'(vif.vso), int'(m_vso));
    if (was_ceo) begin
      if (idx < NREC) begin
        rec_rgb[idx] = vif.rgbo;
        rec_hs[idx]  = vif.hso;
        rec_vs[idx]  = vif.vso;
      end
      nceo++;
    end
  end

  // One input pixel = four clocks: ceo on two of them, cei on the first.
  task automatic pix(input logic [8:0] px, input bit hs);
    @(negedge clock);
    vif.cei = 1; vif.ceo = 1;
    vif.rgbi = px; vif.hsi = hs; vif.vsi = vs_lvl;
    @(negedge clock);
    vif.cei = 0; vif.ceo = 0;
    @(negedge clock);
    vif.ceo = 1;
    @(negedge clock);
    vif.ceo = 0;
  endtask

  task automatic line(input int len, input bit flat, input logic [8:0] cval,
                      input int vs_at, input bit vs_val);
    for (int x = 0; x < len; x++) begin
      if (x == vs_at) vs_lvl = vs_val;
      pix(flat ? cval : 9'((x - 1) & 511), x < 28);
    end
  endtask

  initial begin
    int k, k1, k2, k3, c1, c2;
    bit up;
    vif.cei = 0; vif.ceo = 0; vif.scanl = 0;
    vif.rgbi = 0; vif.hsi = 0; vif.vsi = 0;
    vs_lvl = 0;
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) pix(9'h155, i == 2);
    chk("reset_rgbo", int'(vif.rgbo), 0);
    chk("reset_hso", int'(vif.hso), 0);
    chk("reset_vso", int'(vif.vso), 0);
    reset = 1'b1;

    up = 0;
    for (int i = 0; i < 512 && !up; i++) begin
      pix(9'h000, 1'b0);
      up = vif.hso;
    end
    chk("hso_first_rise", int'(up), 1);

    for (int n = 0; n < 5; n++) line(384, 0, 9'h0, -1, 0);
    k = ls_idx[4];
    chk("st_hs_pre", rec_hs[k], 0);
    chk("st_hs_rise", rec_hs[k+1], 1);
    chk("st_hs_last", rec_hs[k+46], 1);
    chk("st_hs_off", rec_hs[k+47], 0);
    chk("st_hs2_pre", rec_hs[k+384], 0);
    chk("st_hs2_rise", rec_hs[k+385], 1);
    chk("st_px0", int'(rec_rgb[k+1]), 0);
    chk("st_px100", int'(rec_rgb[k+101]), 100);
    chk("st_px2_200", int'(rec_rgb[k+585]), 200);

    vif.scanl = 1;
    for (int n = 5; n < 9; n++) line(385, 1, 9'h1FF, -1, 0);
    k = ls_idx[7];
    c1 = 0; c2 = 0;
    for (int a = 0; a < 384; a++) begin
      if (rec_rgb[k+1+a] == 9'h1FF) c1++;
      if (rec_rgb[k+386+a] == 9'h0DB) c2++;
    end
    chk("scan_first_1ff", c1, 384);
    chk("scan_second_0db", c2, 384);

    vif.scanl = 0;
    for (int n = 9; n < 12; n++) line(385, 1, 9'h1FF, -1, 0);
    k = ls_idx[11];
    c1 = 0;
    for (int a = 0; a < 384; a++) begin
      if (rec_rgb[k+1+a] == 9'h1FF) c1++;
      if (rec_rgb[k+386+a] == 9'h1FF) c1++;
    end
    chk("noscan_1ff", c1, 768);

    line(1500, 0, 9'h0, -1, 0);
    line(600, 0, 9'h0, -1, 0);
    line(384, 0, 9'h0, -1, 0);
    k = ls_idx[13];
    chk("ovl_px5", int'(rec_rgb[k+6]), 5);
    chk("ovl_px700", int'(rec_rgb[k+701]), 188);
    chk("ovl_last", int'(rec_rgb[k+1024]), 474);
    chk("ovl_hs_pre", rec_hs[k+1024], 0);
    chk("ovl_wrap_rise", rec_hs[k+1025], 1);

    line(384, 0, 9'h0, -1, 0);
    line(384, 0, 9'h0, -1, 0);
    line(300, 0, 9'h0, -1, 0);
    line(384, 0, 9'h0, -1, 0);
    line(384, 0, 9'h0, -1, 0);
    k1 = ls_idx[17];
    k2 = ls_idx[18];
    chk("er_hs2", rec_hs[k1+385], 1);
    chk("er_pre", rec_hs[k2], 0);
    chk("er_rise", rec_hs[k2+1], 1);
    c1 = 0;
    for (int m = k1 + 1; m <= k2 + 1; m++)
      if (rec_hs[m] && !rec_hs[m-1]) c1++;
    chk("er_rises", c1, 3);
    chk("er_second_pre", rec_hs[k2+300], 0);
    chk("er_second_rise", rec_hs[k2+301], 1);
    chk("er_px298", int'(rec_rgb[k2+299]), 298);

    line(384, 0, 9'h0, 200, 1);
    line(384, 0, 9'h0, -1, 0);
    line(384, 0, 9'h0, 200, 0);
    line(384, 0, 9'h0, -1, 0);
    k3 = ls_idx[20];
    chk("vs_pre", rec_vs[k3+767], 0);
    chk("vs_rise", rec_vs[k3+768], 1);
    chk("vs_last", rec_vs[k3+2303], 1);
    chk("vs_fall", rec_vs[k3+2304], 0);
    c1 = 0;
    for (int m = k3; m < k3 + 2400; m++) if (rec_vs[m]) c1++;
    chk("vs_width", c1, 1536);
    chk("line_starts", ls_idx.size(), 24);

    for (int x = 0; x < 4; x++) pix(9'((x - 1) & 511), 1'b1);
    chk("pre_reset_hso", int'(vif.hso), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rgbo", int'(vif.rgbo), 0);
    chk("async_hso", int'(vif.hso), 0);
    chk("async_vso", int'(vif.vso), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
